// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle for the HI/LO multiply-divide unit.
// The CPU side drives the request and clock enable; the unit returns status and HI/LO.
interface mips_cpu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             clock_enable;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output clock_enable, start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  clock_enable, start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit. Each enabled cycle performs one radix-2 step on
// operand magnitudes, then a single fix-up cycle restores signs and commits hi/lo.
module mips_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mips_cpu_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] md_q, md_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             b_zero_q, b_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // acc:mq is the shared product / remainder:quotient register pair; md holds the
    // multiplicand or divisor magnitude.
    always_comb begin
        is_signed = ~bus.op[0];
        mag_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, md_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, md_q};
        div_diff  = div_shift[WIDTH-1:0] - md_q;
        prod      = {acc_q, mq_q};
        prod_fix  = neg_res_q ? -prod : prod;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        md_d      = md_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d   = RUN;
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            acc_d     = '0;
                            is_div_d  = bus.op[1];
                            mq_d      = bus.op[1] ? mag_a : mag_b;
                            md_d      = bus.op[1] ? mag_b : mag_a;
                            neg_res_d = is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_rem_d = is_signed & bus.a[WIDTH-1];
                            b_zero_d  = (bus.b == '0);
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                // A zero divisor leaves the dividend in acc, so only lo needs forcing.
                if (is_div_q) begin
                    lo_d = b_zero_q ? '1 : (neg_res_q ? -mq_q : mq_q);
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                dbz_d   = is_div_q & b_zero_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            md_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (bus.clock_enable) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            md_q      <= md_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv: a stimulus process pushes model results into a
// queue and a monitor pops and compares them on every done pulse.
`timescale 1ns/1ps
module tb_mips_cpu_muldiv;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           acc_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    mips_cpu_muldiv_if #(.WIDTH(W)) bus ();

    mips_cpu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t         exp_q[$];
    int           num_checks = 0;
    int           num_fails  = 0;
    int           en_edges   = 0;
    logic [W-1:0] model_hi   = '0;
    logic [W-1:0] model_lo   = '0;
    logic         model_dbz  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.clock_enable) en_edges <= en_edges + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference behaviour from plain 64-bit arithmetic.
    function automatic exp_t modelOp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int ae);
        exp_t                 e;
        longint               sx, sy, sp, sq, sr;
        longint unsigned      ux, uy, up, uq, ur;
        e.acc_edge = ae;
        e.dbz      = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        e.hi = '0;
        e.lo = '0;
        case (o)
            3'd0: begin sp = sx * sy; e.hi = sp[63:32]; e.lo = sp[31:0]; end
            3'd1: begin up = ux * uy; e.hi = up[63:32]; e.lo = up[31:0]; end
            default: begin
                if (y == '0) begin
                    e.hi = x; e.lo = '1; e.dbz = 1'b1;
                end else if (o == 3'd2) begin
                    sq = sx / sy; sr = sx % sy;
                    e.hi = sr[31:0]; e.lo = sq[31:0];
                end else begin
                    uq = ux / uy; ur = ux % uy;
                    e.hi = ur[31:0]; e.lo = uq[31:0];
                end
            end
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        if (o <= 3'd3) begin
            e = modelOp(o, x, y, en_edges + 1);
            exp_q.push_back(e);
            model_hi  = e.hi;
            model_lo  = e.lo;
            model_dbz = e.dbz;
        end else if (o == 3'd4) begin
            model_hi = x;
        end else if (o == 3'd5) begin
            model_lo = x;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Optionally toggles clock_enable and fires start pulses that must be ignored.
    task automatic waitIdle(input bit noisy, input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 400) begin
            if (noisy) begin
                bus.clock_enable = ($urandom_range(0, 5) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    bus.start = 1'b1;
                    bus.op    = 3'($urandom_range(0, 7));
                    bus.a     = $urandom;
                end
            end
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end
        bus.start        = 1'b0;
        bus.clock_enable = 1'b1;
        checkOutput({tag, "_wait_idle"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(model_hi));
        checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(model_lo));
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'(0));
        checkOutput({tag, "_done"}, 64'(bus.done), 64'(0));
        checkOutput({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(model_dbz));
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    num_checks++;
                    num_fails++;
                    $display("[TB] FAIL unexpected_done: done=1 with no pending request, expected done=0");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result_hi", 64'(bus.hi), 64'(e.hi));
                    checkOutput("result_lo", 64'(bus.lo), 64'(e.lo));
                    checkOutput("result_dbz", 64'(bus.div_by_zero), 64'(e.dbz));
                    checkOutput("latency", 64'(en_edges - e.acc_edge), 64'(W + 1));
                end
            end
            prev_done = bus.done;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int busy_cycles;
        int first_done;
        int done_seen;
        logic [2:0] o;

        bus.clock_enable = 1'b0;
        bus.start        = 1'b1;
        bus.op           = 3'b100;
        bus.a            = 32'hAAAA_5555;
        bus.b            = '0;
        reset            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkRegs("reset");
        @(negedge clk);
        reset            = 1'b0;
        bus.clock_enable = 1'b1;

        $display("[TB] MULT -2 * 3");
        applyStimulus(3'd0, 32'hFFFF_FFFE, 32'd3);
        waitIdle(1'b0, "mult");

        $display("[TB] MULTU 0xFFFFFFFE * 3 with busy width");
        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3);
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 100) begin
            busy_cycles++;
            @(posedge clk);
            #1;
        end
        checkOutput("multu_busy_cycles", 64'(busy_cycles), 64'(33));
        checkOutput("multu_done_after_busy", 64'(bus.done), 64'(1));

        $display("[TB] DIV corner cases");
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
        waitIdle(1'b0, "div_neg");
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(1'b0, "div_min");
        applyStimulus(3'd3, 32'd7, 32'd0);
        waitIdle(1'b0, "divu_zero");

        $display("[TB] MTLO keeps hi and div_by_zero");
        applyStimulus(3'd5, 32'h1234_5678, 32'd0);
        checkRegs("mtlo");

        $display("[TB] MULT with five disabled edges");
        applyStimulus(3'd0, 32'h0001_2345, 32'hFFFF_F000);
        first_done = 0;
        for (int e = 1; e <= 45; e++) begin
            @(negedge clk);
            bus.clock_enable = !(e >= 10 && e <= 14);
            @(posedge clk);
            #1;
            if (bus.done && first_done == 0) first_done = e;
        end
        bus.clock_enable = 1'b1;
        checkOutput("ce_gap_done_edge", 64'(first_done), 64'(38));

        $display("[TB] abort by reset");
        applyStimulus(3'd4, 32'hDEAD_BEEF, 32'd0);
        checkRegs("mthi");
        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'h1111_1111;
        @(posedge clk);
        #1;
        checkOutput("busy_mthi_ignored", 64'(bus.hi), 64'(32'hDEAD_BEEF));
        checkOutput("busy_still_set", 64'(bus.busy), 64'(1));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_hi  = '0;
        model_lo  = '0;
        model_dbz = 1'b0;
        checkRegs("abort");
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'(0));

        $display("[TB] randomized sequence");
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1: o = 3'd0;
                2, 3: o = 3'd1;
                4, 5: o = 3'd2;
                6:    o = 3'd3;
                7:    o = 3'd4;
                8:    o = 3'd5;
                default: o = 3'($urandom_range(6, 7));
            endcase
            applyStimulus(o, pickOperand(), pickOperand());
            if (o <= 3'd3) waitIdle(1'b1, "random");
            else checkRegs("random_move");
        end

        repeat (3) @(negedge clk);
        checkOutput("pending_results", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end
endmodule
